// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/ready handshake, hold, flush and an
// optional one-entry skid buffer that makes in_ready registered.
// A saturating counter records cycles where a valid payload is back-pressured.

module pipe_stage_skid #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned SKID   = 0,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              hold,
    input  logic              flush,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic in_fire;
    logic out_fire;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    generate
        if (SKID == 0) begin : g_single
            logic              valid_q, valid_d;
            logic [DATA_W-1:0] data_q, data_d;

            // Ready is combinational: free when empty or when the held payload leaves.
            assign in_ready = (out_ready | ~valid_q) & ~hold;

            // Next state: flush beats a new load, a new load beats a drain.
            always_comb begin
                valid_d = valid_q;
                data_d  = data_q;
                if (flush) begin
                    valid_d = 1'b0;
                end else if (in_fire) begin
                    valid_d = 1'b1;
                    data_d  = in_data;
                end else if (out_fire) begin
                    valid_d = 1'b0;
                end
            end

            // Stage register.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_q <= 1'b0;
                    data_q  <= '0;
                end else begin
                    valid_q <= valid_d;
                    data_q  <= data_d;
                end
            end

            assign out_valid = valid_q;
            assign out_data  = data_q;
            assign occupancy = {1'b0, valid_q};
        end else begin : g_skid
            // Encoding doubles as the entry count.
            typedef enum logic [1:0] {
                StEmpty = 2'd0,
                StOne   = 2'd1,
                StFull  = 2'd2
            } state_e;

            state_e            state_q, state_d;
            logic [DATA_W-1:0] main_q, main_d;
            logic [DATA_W-1:0] skid_q, skid_d;
            logic              ready_q, ready_d;

            // ready_q mirrors "skid entry free" but resets low so in_ready is 0 during reset.
            assign in_ready = ready_q & ~hold;

            // Entry state machine; flush overrides every transition.
            always_comb begin
                state_d = state_q;
                main_d  = main_q;
                skid_d  = skid_q;
                case (state_q)
                    StEmpty: begin
                        if (in_fire) begin
                            state_d = StOne;
                            main_d  = in_data;
                        end
                    end
                    StOne: begin
                        if (in_fire && out_fire) begin
                            main_d = in_data;
                        end else if (in_fire) begin
                            state_d = StFull;
                            skid_d  = in_data;
                        end else if (out_fire) begin
                            state_d = StEmpty;
                        end
                    end
                    StFull: begin
                        if (out_fire) begin
                            state_d = StOne;
                            main_d  = skid_q;
                        end
                    end
                    default: state_d = StEmpty;
                endcase
                if (flush) begin
                    state_d = StEmpty;
                end
                ready_d = (state_d != StFull);
            end

            // Entry registers.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state_q <= StEmpty;
                    main_q  <= '0;
                    skid_q  <= '0;
                    ready_q <= 1'b0;
                end else begin
                    state_q <= state_d;
                    main_q  <= main_d;
                    skid_q  <= skid_d;
                    ready_q <= ready_d;
                end
            end

            assign out_valid = (state_q != StEmpty);
            assign out_data  = main_q;
            assign occupancy = state_q;
        end
    endgenerate

    logic [CNT_W-1:0] stall_q, stall_d;

    // Count back-pressured cycles, flush cycles included, saturating at all-ones.
    always_comb begin
        stall_d = stall_q;
        if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    // Stall counter register; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: one single-register instance (CNT_W=3) and one
// skid instance, with per-instance scoreboards of expected output payloads.

module tb_pipe_stage_skid;

    logic        clk;
    logic        rst;

    logic        v0, r0, ov0, or0, h0, f0;
    logic [31:0] d0, od0;
    logic [1:0]  occ0;
    logic [2:0]  sc0;

    logic        v1, r1, ov1, or1, h1, f1;
    logic [31:0] d1, od1;
    logic [1:0]  occ1;
    logic [15:0] sc1;

    int errors = 0;
    int checks = 0;

    logic [31:0] q0[$];
    logic [31:0] q1[$];

    pipe_stage_skid #(.DATA_W(32), .SKID(0), .CNT_W(3)) u_dut0 (
        .clk(clk), .rst(rst),
        .in_valid(v0), .in_ready(r0), .in_data(d0),
        .out_valid(ov0), .out_ready(or0), .out_data(od0),
        .hold(h0), .flush(f0), .occupancy(occ0), .stall_cnt(sc0)
    );

    pipe_stage_skid #(.DATA_W(32), .SKID(1), .CNT_W(16)) u_dut1 (
        .clk(clk), .rst(rst),
        .in_valid(v1), .in_ready(r1), .in_data(d1),
        .out_valid(ov1), .out_ready(or1), .out_data(od1),
        .hold(h1), .flush(f1), .occupancy(occ1), .stall_cnt(sc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: any valid output must match the oldest expected payload.
    always @(negedge clk) begin
        if (!rst) begin
            if (ov0) begin
                checks++;
                if (q0.size() == 0) begin
                    errors++;
                    $display("FAIL sb0_unexpected: out_data=%h valid with no payload expected", od0);
                end else if (od0 !== q0[0]) begin
                    errors++;
                    $display("FAIL sb0_data: got %h required %h", od0, q0[0]);
                end
                if (or0 && q0.size() != 0) void'(q0.pop_front());
            end
            if (ov1) begin
                checks++;
                if (q1.size() == 0) begin
                    errors++;
                    $display("FAIL sb1_unexpected: out_data=%h valid with no payload expected", od1);
                end else if (od1 !== q1[0]) begin
                    errors++;
                    $display("FAIL sb1_data: got %h required %h", od1, q1[0]);
                end
                if (or1 && q1.size() != 0) void'(q1.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL rst_ov0: got %b required 0", ov0); end
        checks++; if (occ0 !== 2'd0) begin errors++; $display("FAIL rst_occ0: got %0d required 0", occ0); end
        checks++; if (sc0 !== 3'd0) begin errors++; $display("FAIL rst_sc0: got %0d required 0", sc0); end
        checks++; if (od0 !== 32'h0) begin errors++; $display("FAIL rst_od0: got %h required 0", od0); end
        checks++; if (r0 !== 1'b1) begin errors++; $display("FAIL rst_r0: got %b required 1", r0); end
        checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL rst_ov1: got %b required 0", ov1); end
        checks++; if (occ1 !== 2'd0) begin errors++; $display("FAIL rst_occ1: got %0d required 0", occ1); end
        checks++; if (sc1 !== 16'd0) begin errors++; $display("FAIL rst_sc1: got %0d required 0", sc1); end
        checks++; if (od1 !== 32'h0) begin errors++; $display("FAIL rst_od1: got %h required 0", od1); end
        checks++; if (r1 !== 1'b0) begin errors++; $display("FAIL rst_r1: got %b required 0", r1); end
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        @(negedge clk);
        checks++; if (r1 !== 1'b1) begin errors++; $display("FAIL rel_r1: got %b required 1", r1); end
    endtask

    task automatic test_stream();
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k == 0) begin or0 = 1'b1; or1 = 1'b1; end
            if (k < 3) begin
                v0 = 1'b1; v1 = 1'b1; d0 = 32'(k + 1); d1 = 32'(k + 1);
                q0.push_back(32'(k + 1)); q1.push_back(32'(k + 1));
            end else begin
                v0 = 1'b0; v1 = 1'b0;
            end
            @(negedge clk);
            if (k < 3) begin
                checks++; if (r0 !== 1'b1) begin errors++; $display("FAIL stream_r0[%0d]: got %b required 1", k, r0); end
                checks++; if (r1 !== 1'b1) begin errors++; $display("FAIL stream_r1[%0d]: got %b required 1", k, r1); end
            end
            if (k > 0) begin
                checks++; if (ov0 !== 1'b1) begin errors++; $display("FAIL stream_ov0[%0d]: got %b required 1", k, ov0); end
                checks++; if (ov1 !== 1'b1) begin errors++; $display("FAIL stream_ov1[%0d]: got %b required 1", k, ov1); end
            end
        end
        tick();
        @(negedge clk);
        checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL stream_end_ov0: got %b required 0", ov0); end
        checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL stream_end_ov1: got %b required 0", ov1); end
        checks++; if (sc0 !== 3'd0) begin errors++; $display("FAIL stream_sc0: got %0d required 0", sc0); end
        checks++; if (sc1 !== 16'd0) begin errors++; $display("FAIL stream_sc1: got %0d required 0", sc1); end
        checks++; if (q0.size() != 0 || q1.size() != 0) begin
            errors++; $display("FAIL stream_drain: left %0d/%0d required 0/0", q0.size(), q1.size());
        end
    endtask

    task automatic test_backpressure();
        tick(); or1 = 1'b0; v1 = 1'b1; d1 = 32'hA; q1.push_back(32'hA);
        @(negedge clk);
        checks++; if (r1 !== 1'b1) begin errors++; $display("FAIL bp_r1_a: got %b required 1", r1); end
        tick(); d1 = 32'hB; q1.push_back(32'hB);
        @(negedge clk);
        checks++; if (occ1 !== 2'd1) begin errors++; $display("FAIL bp_occ_1: got %0d required 1", occ1); end
        checks++; if (r1 !== 1'b1) begin errors++; $display("FAIL bp_r1_b: got %b required 1", r1); end
        checks++; if (sc1 !== 16'd0) begin errors++; $display("FAIL bp_sc_0: got %0d required 0", sc1); end
        tick(); v1 = 1'b0;
        @(negedge clk);
        checks++; if (occ1 !== 2'd2) begin errors++; $display("FAIL bp_occ_2: got %0d required 2", occ1); end
        checks++; if (r1 !== 1'b0) begin errors++; $display("FAIL bp_r1_full: got %b required 0", r1); end
        checks++; if (od1 !== 32'hA) begin errors++; $display("FAIL bp_od_a: got %h required a", od1); end
        checks++; if (sc1 !== 16'd1) begin errors++; $display("FAIL bp_sc_1: got %0d required 1", sc1); end
        tick();
        @(negedge clk);
        checks++; if (occ1 !== 2'd2) begin errors++; $display("FAIL bp_occ_2b: got %0d required 2", occ1); end
        checks++; if (sc1 !== 16'd2) begin errors++; $display("FAIL bp_sc_2: got %0d required 2", sc1); end
        tick(); or1 = 1'b1;
        @(negedge clk);
        checks++; if (sc1 !== 16'd3) begin errors++; $display("FAIL bp_sc_3: got %0d required 3", sc1); end
        tick();
        @(negedge clk);
        checks++; if (occ1 !== 2'd1) begin errors++; $display("FAIL bp_occ_back1: got %0d required 1", occ1); end
        checks++; if (r1 !== 1'b1) begin errors++; $display("FAIL bp_r1_back: got %b required 1", r1); end
        tick();
        @(negedge clk);
        checks++; if (occ1 !== 2'd0) begin errors++; $display("FAIL bp_occ_0: got %0d required 0", occ1); end
        checks++; if (sc1 !== 16'd3) begin errors++; $display("FAIL bp_sc_final: got %0d required 3", sc1); end
        checks++; if (q1.size() != 0) begin errors++; $display("FAIL bp_drain: left %0d required 0", q1.size()); end
    endtask

    task automatic test_hold();
        tick(); v0 = 1'b1; d0 = 32'h55; q0.push_back(32'h55);
        @(negedge clk);
        checks++; if (r0 !== 1'b1) begin errors++; $display("FAIL hold_r0_pre: got %b required 1", r0); end
        tick(); d0 = 32'h66; h0 = 1'b1;
        @(negedge clk);
        checks++; if (ov0 !== 1'b1) begin errors++; $display("FAIL hold_ov0: got %b required 1", ov0); end
        checks++; if (r0 !== 1'b0) begin errors++; $display("FAIL hold_r0: got %b required 0", r0); end
        tick();
        @(negedge clk);
        checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL hold_drained: got %b required 0", ov0); end
        checks++; if (r0 !== 1'b0) begin errors++; $display("FAIL hold_r0_empty: got %b required 0", r0); end
        tick(); h0 = 1'b0; q0.push_back(32'h66);
        @(negedge clk);
        checks++; if (r0 !== 1'b1) begin errors++; $display("FAIL hold_r0_rel: got %b required 1", r0); end
        tick(); v0 = 1'b0;
        @(negedge clk);
        checks++; if (od0 !== 32'h66 || ov0 !== 1'b1) begin
            errors++; $display("FAIL hold_out66: got valid=%b data=%h required valid=1 data=66", ov0, od0);
        end
        tick();
        @(negedge clk);
        checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL hold_end: got %b required 0", ov0); end
    endtask

    task automatic test_flush();
        tick(); or1 = 1'b0; v1 = 1'b1; d1 = 32'h1A; q1.push_back(32'h1A);
        tick(); d1 = 32'h1B; q1.push_back(32'h1B);
        @(negedge clk);
        checks++; if (occ1 !== 2'd1) begin errors++; $display("FAIL fl_occ1: got %0d required 1", occ1); end
        tick(); d1 = 32'hC; f1 = 1'b1;
        @(negedge clk);
        checks++; if (occ1 !== 2'd2) begin errors++; $display("FAIL fl_occ2: got %0d required 2", occ1); end
        checks++; if (r1 !== 1'b0) begin errors++; $display("FAIL fl_r1_full: got %b required 0", r1); end
        tick(); f1 = 1'b0; v1 = 1'b0; q1.delete();
        @(negedge clk);
        checks++; if (occ1 !== 2'd0) begin errors++; $display("FAIL fl_occ0: got %0d required 0", occ1); end
        checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL fl_ov1: got %b required 0", ov1); end
        checks++; if (sc1 !== 16'd5) begin errors++; $display("FAIL fl_sc1: got %0d required 5", sc1); end
        // A payload offered alongside flush must be dropped.
        tick(); or1 = 1'b1; v0 = 1'b1; v1 = 1'b1; d0 = 32'hE; d1 = 32'hE; f0 = 1'b1; f1 = 1'b1;
        @(negedge clk);
        checks++; if (r0 !== 1'b1) begin errors++; $display("FAIL fl_r0_same: got %b required 1", r0); end
        checks++; if (r1 !== 1'b1) begin errors++; $display("FAIL fl_r1_same: got %b required 1", r1); end
        tick(); v0 = 1'b0; v1 = 1'b0; f0 = 1'b0; f1 = 1'b0;
        @(negedge clk);
        checks++; if (ov0 !== 1'b0 || occ0 !== 2'd0) begin
            errors++; $display("FAIL fl_drop0: got valid=%b occ=%0d required 0/0", ov0, occ0);
        end
        checks++; if (ov1 !== 1'b0 || occ1 !== 2'd0) begin
            errors++; $display("FAIL fl_drop1: got valid=%b occ=%0d required 0/0", ov1, occ1);
        end
    endtask

    task automatic test_saturation();
        tick(); or0 = 1'b0; v0 = 1'b1; d0 = 32'h77; q0.push_back(32'h77);
        tick(); v0 = 1'b0;
        for (int i = 0; i < 11; i++) begin
            int e;
            e = (i > 7) ? 7 : i;
            @(negedge clk);
            checks++; if (sc0 !== 3'(e)) begin errors++; $display("FAIL sat_sc0[%0d]: got %0d required %0d", i, sc0, e); end
            tick();
        end
        or0 = 1'b1;
        tick();
        @(negedge clk);
        checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL sat_drain: got %b required 0", ov0); end
        checks++; if (sc0 !== 3'd7) begin errors++; $display("FAIL sat_hold7: got %0d required 7", sc0); end
    endtask

    task automatic test_async_reset();
        tick(); or1 = 1'b0; v1 = 1'b1; d1 = 32'h21; q1.push_back(32'h21);
        tick(); d1 = 32'h22; q1.push_back(32'h22);
        tick(); v1 = 1'b0;
        #2;
        checks++; if (occ1 !== 2'd2) begin errors++; $display("FAIL ar_occ_pre: got %0d required 2", occ1); end
        checks++; if (sc1 !== 16'd6) begin errors++; $display("FAIL ar_sc_pre: got %0d required 6", sc1); end
        rst = 1'b1;
        q0.delete(); q1.delete();
        #1;
        checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL ar_ov1: got %b required 0", ov1); end
        checks++; if (occ1 !== 2'd0) begin errors++; $display("FAIL ar_occ1: got %0d required 0", occ1); end
        checks++; if (sc1 !== 16'd0) begin errors++; $display("FAIL ar_sc1: got %0d required 0", sc1); end
        checks++; if (r1 !== 1'b0) begin errors++; $display("FAIL ar_r1: got %b required 0", r1); end
        checks++; if (od1 !== 32'h0) begin errors++; $display("FAIL ar_od1: got %h required 0", od1); end
        checks++; if (sc0 !== 3'd0) begin errors++; $display("FAIL ar_sc0: got %0d required 0", sc0); end
        @(posedge clk);
        #1 rst = 1'b0;
        tick(); or1 = 1'b1; v1 = 1'b1; d1 = 32'h31; q1.push_back(32'h31);
        @(negedge clk);
        checks++; if (r1 !== 1'b1) begin errors++; $display("FAIL ar_r1_rel: got %b required 1", r1); end
        checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL ar_ov1_rel: got %b required 0", ov1); end
        tick(); v1 = 1'b0;
        @(negedge clk);
        checks++; if (ov1 !== 1'b1 || od1 !== 32'h31) begin
            errors++; $display("FAIL ar_first: got valid=%b data=%h required valid=1 data=31", ov1, od1);
        end
        tick();
        @(negedge clk);
        checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL ar_end: got %b required 0", ov1); end
    endtask

    initial begin
        rst = 1'b1;
        v0 = 1'b0; or0 = 1'b0; h0 = 1'b0; f0 = 1'b0; d0 = '0;
        v1 = 1'b0; or1 = 1'b0; h1 = 1'b0; f1 = 1'b0; d1 = '0;
        test_reset();
        test_stream();
        test_backpressure();
        test_hold();
        test_flush();
        test_saturation();
        test_async_reset();
        checks++; if (q0.size() != 0 || q1.size() != 0) begin
            errors++; $display("FAIL final_drain: left %0d/%0d required 0/0", q0.size(), q1.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
